// File: rtl/apb_ram_arbiter.sv
// Round-robin APB master that shares one APB RAM slave between NUM_REQ requesters.
// Optional feature macro APB_ARB_TIMEOUT_EN: ends ACCESS phases stalled for TIMEOUT_CYC cycles.

module apb_ram_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_last_grant;
  logic [IDX_W-1:0]      r_grant;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_found;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W-1:0]      w_cand;
  logic                  w_timeout;
  logic                  w_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A requester being acknowledged this cycle is still holding req; ignore it once.
  assign w_elig = req & ~r_ack;

  // Round-robin search upward from the requester after the last one served.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = {IDX_W{1'b0}};
    w_cand    = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_found && w_elig[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end else begin
        w_found   = w_found;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_to_cnt;

  assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_to_cnt == CNT_W'(TIMEOUT_CYC));

  // Stall counter: cleared on the way into ACCESS, counts PREADY-low cycles there.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_to_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_SETUP) begin
      r_to_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_ACCESS) && !PREADY && !w_timeout) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == ST_ACCESS) && (PREADY || w_timeout);

  // Transfer sequencer: IDLE grant/latch, SETUP, ACCESS completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= {IDX_W{1'b0}};
      r_ack        <= {NUM_REQ{1'b0}};
      r_rdata      <= {DATA_WIDTH{1'b0}};
      r_err        <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= {ADDR_WIDTH{1'b0}};
      r_pwdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ack   <= {NUM_REQ{1'b0}};
      r_rdata <= {DATA_WIDTH{1'b0}};
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant  <= w_gnt_idx;
            r_pwrite <= req_write[w_gnt_idx];
            r_paddr  <= w_addr_arr[w_gnt_idx];
            r_pwdata <= w_wdata_arr[w_gnt_idx];
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_ack        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
            r_rdata      <= (r_pwrite || w_timeout) ? {DATA_WIDTH{1'b0}} : PRDATA;
            r_err        <= w_timeout ? 1'b1 : PSLVERR;
            r_last_grant <= r_grant;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state      <= ST_ACCESS;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

  apb_ram_arbiter_chk #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .ack       (r_ack),
    .rsp_rdata (r_rdata),
    .rsp_err   (r_err),
    .PSEL      (r_psel),
    .PENABLE   (r_penable),
    .PWRITE    (r_pwrite),
    .PADDR     (r_paddr),
    .PWDATA    (r_pwdata)
  );

endmodule

// Protocol properties of the arbiter's APB master and response outputs.
module apb_ram_arbiter_chk #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic                  PCLK,
  input logic                  PRESET,
  input logic [NUM_REQ-1:0]    ack,
  input logic [DATA_WIDTH-1:0] rsp_rdata,
  input logic                  rsp_err,
  input logic                  PSEL,
  input logic                  PENABLE,
  input logic                  PWRITE,
  input logic [ADDR_WIDTH-1:0] PADDR,
  input logic [DATA_WIDTH-1:0] PWDATA
);

  a_ack_onehot: assert property (@(posedge PCLK) disable iff (PRESET)
    $onehot0(ack)) else $error("ack is not one-hot");

  a_enable_needs_sel: assert property (@(posedge PCLK) disable iff (PRESET)
    PENABLE |-> PSEL) else $error("PENABLE without PSEL");

  a_rsp_quiet: assert property (@(posedge PCLK) disable iff (PRESET)
    (ack == {NUM_REQ{1'b0}}) |-> (!rsp_err && (rsp_rdata == {DATA_WIDTH{1'b0}})))
    else $error("response driven without ack");

  a_setup_to_access: assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && !PENABLE) |=> (PSEL && PENABLE)) else $error("SETUP not followed by ACCESS");

  a_payload_stable: assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && $past(PSEL)) |-> ($stable(PADDR) && $stable(PWRITE) && $stable(PWDATA)))
    else $error("APB payload changed during transfer");

endmodule

// File: doc/apb_ram_arbiter.md
# apb_ram_arbiter

Round-robin APB master that shares one APB RAM slave (`apb_ram_interface`) between `NUM_REQ` internal requesters. It accepts simple request/acknowledge transactions, serialises them, and drives the APB SETUP and ACCESS phases. It honours `PREADY` wait states and returns `PRDATA`/`PSLVERR` to the granted requester. It sits between on-chip clients (DMA, CPU bridge, test engine) and the RAM slave's APB port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 10: APB/RAM address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYC`, 16: ACCESS-phase wait limit; used only with `APB_ARB_TIMEOUT_EN`.

Ports:
- `PCLK` in 1: sole clock, rising edge.
- `PRESET` in 1: reset, synchronous, active-high.
- `req` in `NUM_REQ`: per-requester request level.
- `req_write` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ*ADDR_WIDTH`: flattened addresses; requester i occupies slice i.
- `req_wdata` in `NUM_REQ*DATA_WIDTH`: flattened write data.
- `ack` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `rsp_rdata` out `DATA_WIDTH`: read data, valid while `ack` is high.
- `rsp_err` out 1: error flag, valid while `ack` is high.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB master controls.
- `PADDR` out `ADDR_WIDTH`; `PWDATA` out `DATA_WIDTH`.
- `PRDATA` in `DATA_WIDTH`; `PREADY` in 1; `PSLVERR` in 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - The grant goes to the first asserted `req` bit, searching upward from `last_grant+1` modulo `NUM_REQ`.
  - Any requester whose `ack` is high in the current cycle is masked.
  - On a grant, latch `req_write`, `req_addr` and `req_wdata` slices into `PWRITE`/`PADDR`/`PWDATA`, set `PSEL`=1, and go to SETUP.
  - With no eligible request, stay in IDLE.
- **SETUP:** set `PENABLE`=1 and go to ACCESS. `PADDR`, `PWRITE`, `PWDATA` and `PSEL` are held.
- **ACCESS:**
  - `PREADY`=0: hold all APB outputs.
  - `PREADY`=1: register `PRDATA` (reads; 0 for writes) into `rsp_rdata` and `PSLVERR` into `rsp_err`, pulse `ack[grant]`, update `last_grant`, clear `PSEL` and `PENABLE`, and go to IDLE.
- Requester rules:
  - Hold `req` and the payload until `ack`.
  - Drop `req` in the `ack` cycle, or it is treated as a new request from the next cycle.
  - The payload is sampled only at grant.
  - Deasserting `req` before `ack` does not abort a granted transfer.
- Reset values:
  - state IDLE; `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
  - All outputs 0: `ack`, `rsp_rdata`, `rsp_err`, `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`.
- Reset mid-transfer: on the next edge `PSEL`/`PENABLE` drop to 0 and no `ack` is issued. The requester must re-request.

## Timing
- All outputs are registered.
- Zero-wait transfer, with `req` sampled at edge E0:
  - `PSEL`=1 after E0.
  - `PENABLE`=1 after E1.
  - `PREADY` sampled at E2; `ack`/`rsp_*` valid after E2.
  - Total: 3 cycles from request to `ack`.
- Each `PREADY`=0 cycle in ACCESS adds one cycle.
- Back-to-back: the next grant can be sampled at the same edge E2+1 where `ack` is visible, giving `PSEL` high again one cycle after `ack`. Peak throughput is one transfer per 3 cycles.
- `PSEL` never drops between SETUP and ACCESS completion.
- `PADDR`/`PWRITE`/`PWDATA` are stable from SETUP through ACCESS completion.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter increments on each ACCESS cycle with `PREADY`=0 and clears on entering ACCESS.
  - When it reaches `TIMEOUT_CYC`, the transfer terminates: `ack[grant]`=1, `rsp_err`=1, `rsp_rdata`=0, `PSEL`/`PENABLE` cleared, state IDLE, `last_grant` updated.
- Undefined: no counter; ACCESS waits indefinitely for `PREADY`.

## Test plan
- Single write: requester 0 writes 0x001 with 0xDEADBEEF, then reads 0x001 -> `PSEL`/`PENABLE` sequence correct, each `ack[0]` 3 cycles after `req`, read `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Contention: all 4 requesters assert after reset, each held until `ack` -> grants in order 0,1,2,3. Requester 0 re-asserts immediately and is served after 3; no requester is starved.
- Wait states: slave holds `PREADY`=0 for 2 cycles -> `ack` at cycle 5, APB outputs stable throughout ACCESS.
- Error: `PSLVERR`=1 with `PREADY` on a read of 0x3FF -> `rsp_err`=1 for exactly the `ack` cycle; next transfer shows `rsp_err`=0.
- Reset mid-ACCESS: assert `PRESET` while `PENABLE`=1 -> next cycle all outputs 0, no `ack`; the post-reset request from requester 2 is served normally.
- Timeout (`APB_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=16): `PREADY` stuck 0 -> `ack` with `rsp_err`=1, `rsp_rdata`=0 after 16 wait cycles; without the macro, no `ack` within 100 cycles.
